matrix_addsub_seq: RTL and testbench

Sequential, parametrised successor to the combinational element-wise matrix adder. It accepts two packed HxW matrices through a valid/ready handshake and applies one of four modes: add, subtract, accumulate or clear. It processes LANES elements per cycle, with optional saturation and a sticky overflow flag. It sits in the RBM datapath for weight/bias update (W += dW) where a full HxW adder array is too large.

---
 rtl/matrix_addsub_seq_pkg.sv | 13 +
 rtl/matrix_addsub_seq_elem_addsub.sv | 25 ++
 rtl/matrix_addsub_seq.sv | 107 ++++++++++
 tb/tb_matrix_addsub_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_addsub_seq_pkg.sv
// matrix_addsub_seq_pkg: shared mode encodings, FSM states and port-width helper for matrix_addsub_seq.
package matrix_addsub_seq_pkg;
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    function automatic int port_2d(input int h, input int w, input int b);
        return h * w * b;
    endfunction
endpackage

// File: rtl/matrix_addsub_seq_elem_addsub.sv
// elem_addsub: single-element signed add/sub with optional saturation and overflow flag.
module elem_addsub #(
    parameter int BITLENGTH = 8,
    parameter int SATURATE  = 1
) (
    input  logic [BITLENGTH-1:0] a,
    input  logic [BITLENGTH-1:0] b,
    input  logic                 sub,
    output logic [BITLENGTH-1:0] sum,
    output logic                 ovf
);
    localparam logic [BITLENGTH-1:0] VMAX = {1'b0, {(BITLENGTH-1){1'b1}}};
    localparam logic [BITLENGTH-1:0] VMIN = {1'b1, {(BITLENGTH-1){1'b0}}};

    logic [BITLENGTH:0] ae, be, r;

    always_comb begin
        ae  = {a[BITLENGTH-1], a};
        be  = {b[BITLENGTH-1], b};
        r   = sub ? ae - be : ae + be;
        // one guard bit: disagreement with the sign bit means the result left the range
        ovf = r[BITLENGTH] != r[BITLENGTH-1];
        sum = (SATURATE != 0 && ovf) ? (r[BITLENGTH] ? VMIN : VMAX) : r[BITLENGTH-1:0];
    end
endmodule

// File: rtl/matrix_addsub_seq.sv
// matrix_addsub_seq: sequential element-wise matrix add/sub/acc/clear, LANES elements per cycle.
module matrix_addsub_seq
    import matrix_addsub_seq_pkg::*;
#(
    parameter int BITLENGTH = 8,
    parameter int H         = 3,
    parameter int W         = 4,
    parameter int LANES     = 4,
    parameter int SATURATE  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [1:0]                            mode,
    input  logic [port_2d(H, W, BITLENGTH)-1:0]   ai,
    input  logic [port_2d(H, W, BITLENGTH)-1:0]   bi,
    output logic [port_2d(H, W, BITLENGTH)-1:0]   co,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  overflow
);
    localparam int NB = port_2d(H, W, BITLENGTH);
    localparam int C  = (H * W) / LANES;
    localparam int CW = C > 1 ? $clog2(C) : 1;

    if ((H * W) % LANES != 0) begin : g_bad_lanes
        $error("LANES must divide H*W");
    end

    state_e                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [NB-1:0]                   a_q, a_d, b_q, b_d, r_q, r_d;
    logic [1:0]                      mode_q, mode_d;
    logic                            ovf_q, ovf_d;
    logic [LANES-1:0][BITLENGTH-1:0] lane_sum;
    logic [LANES-1:0]                lane_ovf;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [BITLENGTH-1:0] ra, aa, bb, s;
        logic                 o;
        assign ra = r_q[(32'(cnt_q) * LANES + l) * BITLENGTH +: BITLENGTH];
        assign aa = a_q[(32'(cnt_q) * LANES + l) * BITLENGTH +: BITLENGTH];
        assign bb = b_q[(32'(cnt_q) * LANES + l) * BITLENGTH +: BITLENGTH];
        elem_addsub #(.BITLENGTH(BITLENGTH), .SATURATE(SATURATE)) u_elem (
            .a  (mode_q == MODE_ACC ? ra : aa),
            .b  (mode_q == MODE_ACC ? aa : bb),
            .sub(mode_q == MODE_SUB),
            .sum(s),
            .ovf(o)
        );
        assign lane_sum[l] = mode_q == MODE_CLR ? '0 : s;
        assign lane_ovf[l] = mode_q != MODE_CLR && o;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        if (state_q == S_IDLE && in_valid) begin
            a_d     = ai;
            b_d     = bi;
            mode_d  = mode;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_RUN;
        end
        if (state_q == S_RUN) begin
            for (int l = 0; l < LANES; l++)
                r_d[(32'(cnt_q) * LANES + l) * BITLENGTH +: BITLENGTH] = lane_sum[l];
            ovf_d   = ovf_q | (|lane_ovf);
            cnt_d   = cnt_q == CW'(C - 1) ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == CW'(C - 1) ? S_DONE : S_RUN;
        end
        if (state_q == S_DONE && out_ready)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_ADD;
            r_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign co        = r_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_matrix_addsub_seq.sv
// tb_matrix_addsub_seq: scoreboard bench over three matrix_addsub_seq configurations.
module tb_matrix_addsub_seq;
    import matrix_addsub_seq_pkg::*;

    localparam int ND = 3;
    localparam int NB = port_2d(3, 4, 8);
    localparam int LN  [ND] = '{4, 12, 1};
    localparam int SAT [ND] = '{1, 0, 1};

    typedef struct {
        int            d;
        logic [NB-1:0] co;
        logic          ovf;
        int            k;
    } exp_t;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          rst_n;
    logic          in_valid  [ND];
    logic          in_ready  [ND];
    logic          out_valid [ND];
    logic          out_ready [ND];
    logic          overflow  [ND];
    logic [1:0]    mode      [ND];
    logic [NB-1:0] ai        [ND];
    logic [NB-1:0] bi        [ND];
    logic [NB-1:0] co        [ND];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    exp_t          exp_q[$];

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm, input string act, input string req);
        n_chk++;
        n_fail++;
        $display("FAIL %s: actual %s required %s", nm, act, req);
    endtask

    function automatic logic [NB-1:0] fill(input logic [7:0] v);
        logic [NB-1:0] r;
        for (int f = 0; f < 12; f++) r[f*8 +: 8] = v;
        return r;
    endfunction

    for (genvar d = 0; d < ND; d++) begin : g_dut
        localparam int C = 12 / LN[d];
        logic pv;
        matrix_addsub_seq #(.BITLENGTH(8), .H(3), .W(4), .LANES(LN[d]), .SATURATE(SAT[d])) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[d]),
            .in_ready (in_ready[d]),
            .mode     (mode[d]),
            .ai       (ai[d]),
            .bi       (bi[d]),
            .co       (co[d]),
            .out_valid(out_valid[d]),
            .out_ready(out_ready[d]),
            .overflow (overflow[d])
        );
        always @(negedge clk) begin
            if (!rst_n) begin
                pv <= 1'b0;
            end else begin
                if (out_valid[d] && !pv) begin
                    if (exp_q.size() == 0 || exp_q[0].d != d)
                        fail($sformatf("unexpected_out_valid_dut%0d", d), "1", "0");
                    else
                        chk($sformatf("latency_dut%0d", d), NB'(cyc - exp_q[0].k), NB'(C));
                end
                if (out_valid[d] && out_ready[d] && exp_q.size() > 0 && exp_q[0].d == d) begin
                    chk($sformatf("co_dut%0d", d), co[d], exp_q[0].co);
                    chk($sformatf("overflow_dut%0d", d), NB'(overflow[d]), NB'(exp_q[0].ovf));
                    void'(exp_q.pop_front());
                end
                pv <= out_valid[d];
            end
        end
    end

    // Issue one operation, optionally hold the result for `hold` cycles, then consume it.
    task automatic op(input int d, input logic [1:0] m, input logic [NB-1:0] a, input logic [NB-1:0] b,
                      input logic [NB-1:0] e, input logic eo, input int hold);
        int n;
        chk($sformatf("in_ready_idle_dut%0d", d), NB'(in_ready[d]), NB'(1));
        mode[d] = m;
        ai[d] = a;
        bi[d] = b;
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{d, e, eo, cyc});
        in_valid[d] = 1'b0;
        ai[d] = ~a;
        bi[d] = ~b;
        mode[d] = MODE_CLR;
        n = 0;
        while (!out_valid[d] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid[d]) begin
            fail($sformatf("timeout_dut%0d", d), "no out_valid", "out_valid");
            exp_q.delete();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            chk($sformatf("hold_out_valid_dut%0d", d), NB'(out_valid[d]), NB'(1));
            chk($sformatf("hold_in_ready_dut%0d", d), NB'(in_ready[d]), NB'(0));
            in_valid[d] = i == 1;
            mode[d] = MODE_ADD;
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        chk($sformatf("in_ready_after_done_dut%0d", d), NB'(in_ready[d]), NB'(1));
        chk($sformatf("out_valid_after_done_dut%0d", d), NB'(out_valid[d]), NB'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] a, e;
        for (int d = 0; d < ND; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
            mode[d] = MODE_ADD;
            ai[d] = '0;
            bi[d] = '0;
        end
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset_co_dut%0d", d), co[d], '0);
            chk($sformatf("reset_out_valid_dut%0d", d), NB'(out_valid[d]), NB'(0));
            chk($sformatf("reset_overflow_dut%0d", d), NB'(overflow[d]), NB'(0));
            chk($sformatf("reset_in_ready_dut%0d", d), NB'(in_ready[d]), NB'(1));
        end
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        op(0, MODE_ADD, fill(8'd5), fill(8'd7), fill(8'd12), 1'b0, 0);
        op(0, MODE_SUB, fill(-8'sd100), fill(8'd100), fill(8'h80), 1'b1, 0);
        op(1, MODE_SUB, fill(-8'sd100), fill(8'd100), fill(8'd56), 1'b1, 0);
        op(0, MODE_CLR, fill(8'd55), fill(8'd66), '0, 1'b0, 0);
        op(0, MODE_ACC, fill(8'd3), fill(8'd99), fill(8'd3), 1'b0, 0);
        op(0, MODE_ACC, fill(8'd3), fill(8'd99), fill(8'd6), 1'b0, 0);
        op(0, MODE_ACC, fill(8'd3), fill(8'd99), fill(8'd9), 1'b0, 5);
        op(0, MODE_ADD, fill(8'd100), fill(8'd27), fill(8'd127), 1'b0, 0);
        op(1, MODE_ADD, fill(-8'sd5), fill(8'd3), fill(-8'sd2), 1'b0, 0);
        op(2, MODE_SUB, fill(-8'sd1), fill(8'd127), fill(8'h80), 1'b0, 0);

        for (int f = 0; f < 12; f++) begin
            a[f*8 +: 8] = 8'(10 * f);
            e[f*8 +: 8] = 8'(10 * f + 20);
        end
        op(1, MODE_ADD, a, fill(8'd20), e, 1'b1, 0);
        for (int f = 0; f < 12; f++) begin
            a[f*8 +: 8] = f == 0 ? 8'd120 : 8'(f);
            e[f*8 +: 8] = f == 0 ? 8'd127 : 8'(f + 20);
        end
        op(2, MODE_ADD, a, fill(8'd20), e, 1'b1, 0);

        chk("abort_in_ready", NB'(in_ready[0]), NB'(1));
        mode[0] = MODE_ADD;
        ai[0] = fill(8'd9);
        bi[0] = fill(8'd9);
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_co", co[0], '0);
        chk("abort_out_valid", NB'(out_valid[0]), NB'(0));
        chk("abort_overflow", NB'(overflow[0]), NB'(0));
        chk("abort_in_ready_after_reset", NB'(in_ready[0]), NB'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        op(0, MODE_ADD, fill(8'd1), fill(8'd1), fill(8'd2), 1'b0, 0);

        repeat (5) @(posedge clk);
        #1;
        if (exp_q.size() != 0)
            fail("scoreboard_drain", $sformatf("%0d pending", exp_q.size()), "0 pending");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
